plot_arbiter: RTL and testbench
===============================

// Module: plot_arbiter
// PURPOSE
//  Frame-buffer write sequencer between game logic (snake datapath, food generator) and vga_adapter.
//  After reset, and on request, it clears the 160x120 screen. It then serialises pixel-write requests
//  from three channels into a single x/y/colour/plot stream, at most one write per clock.
//  It replaces the combinational food/snake mux and the tied-high plot enable.
// PARAMETERS
//  WIDTH          160     screen width in pixels; x range 0..WIDTH-1
//  HEIGHT         120     screen height in pixels; y range 0..HEIGHT-1
//  CLEAR_COLOUR   3'b000  colour written by the clear sweep
//  BORDER_COLOUR  3'b111  border colour (BORDER_EN builds only)
// PORTS
//  clk           in   1  system clock (CLOCK_50 domain)
//  resetn        in   1  asynchronous, active-low reset
//  clear_req     in   1  pulse: start a full-screen clear sweep (ignored while clearing)
//  er_req/er_ack in/out 1/1  ch0, erase tail: request / 1-cycle grant pulse
//  er_x, er_y    in   8/7 ch0 pixel coordinates; colour is forced to CLEAR_COLOUR
//  hd_req/hd_ack in/out 1/1  ch1, draw snake head
//  hd_x,hd_y,hd_c in  8/7/3 ch1 pixel coordinates and colour
//  fd_req/fd_ack in/out 1/1  ch2, draw food
//  fd_x,fd_y,fd_c in  8/7/3 ch2 pixel coordinates and colour
//  x, y, colour  out  8/7/3 registered pixel to vga_adapter
//  plot          out  1  registered write enable to vga_adapter
//  busy          out  1  high while a clear sweep is in progress
//  oob           out  1  1-cycle pulse: granted request was dropped (out of range)
// BEHAVIOUR
//  Reset (async assert) values: x=0, y=0, colour=0, plot=0, all acks=0, oob=0, busy=1; state=CLEAR; sweep counters=0.
//  The first sweep pixel is registered on the first clk edge after resetn deasserts.
//  CLEAR state:
//   - Raster sweep: x increments 0..WIDTH-1; at wrap, x returns to 0 and y increments; y runs 0..HEIGHT-1.
//   - Each cycle: plot=1, colour=CLEAR_COLOUR. Exactly WIDTH*HEIGHT (19200) plot cycles.
//   - No acks are issued; requests are held pending, not lost.
//  After pixel (WIDTH-1,HEIGHT-1) is written, the next cycle is SERVE: busy=0, plot=0.
//  Requests are sampled from that cycle on.
//  SERVE state, per cycle:
//   - Eligible channel = req high AND its own ack not high this cycle.
//   - A channel is therefore granted at most every other cycle, so a held req never double-writes.
//   - Fixed priority among eligible channels: ch0 > ch1 > ch2.
//   - Winner is granted at edge N; at N+1 (1-cycle latency): ack=1, plot=1, x/y/colour = winner data.
//   - No eligible request: plot=0, x/y/colour hold their last values.
//  Requester rules:
//   - Hold req and data stable until ack is seen.
//   - Drop req, or present new data, in the cycle after ack.
//  Out of range (x>=WIDTH or y>=HEIGHT): grant still issues ack; plot=0, oob=1 that cycle; no write.
//  clear_req:
//   - In SERVE, sampled high: it wins over all channels.
//   - Next cycle: CLEAR, busy=1, sweep restarts at (0,0).
//   - Coincident with an ack cycle: that ack's write still completes first.
//   - In CLEAR: ignored, no restart.
//  Widths: x/y sweep counters are 8/7 bits; comparisons are against WIDTH-1/HEIGHT-1 (no natural overflow).
//  Reset mid-sweep or mid-grant: outputs return to reset values at once; the sweep restarts from (0,0).
// CONFIGURATION
//  BORDER_EN defined:
//   - Sweep pixels with x==0, x==WIDTH-1, y==0 or y==HEIGHT-1 are written in BORDER_COLOUR.
//   - In SERVE, requests that target a border pixel are treated as out of range (ack, plot=0, oob=1).
//  BORDER_EN undefined:
//   - The whole sweep uses CLEAR_COLOUR.
//   - Border pixels are ordinary writable pixels.
// TESTING
//  T1 reset release -> 19200 consecutive plot=1 cycles; first (0,0) colour 0, last (159,119); busy 1->0 the next cycle.
//  T2 er/hd/fd req high together in SERVE -> plots: er on cycle N+1, hd on N+2, fd on N+3.
//     In that test er_req is dropped after er_ack, and only one ack is high per cycle.
//  T3 hd_req held 4 cycles with hd_x=10, hd_y=20, hd_c=3'b010 -> exactly 2 writes of (10,20,010), acked on alternate cycles.
//  T4 fd_x=160, fd_y=5 -> fd_ack=1, oob=1, plot=0; frame unchanged. Repeat with fd_y=120: same result.
//  T5 clear_req pulse in SERVE while hd_req is pending -> busy=1; sweep restarts at (0,0); hd_ack is issued only after 19200 cycles.
//     Then assert resetn=0 mid-sweep -> plot=0 immediately; sweep restarts at (0,0) after release.
//  T6 BORDER_EN defined -> sweep pixel (0,50) and pixel (80,119) are colour 111, pixel (80,60) is 000.
//     A request to (0,50) gives oob=1 and no write.

Source files
------------

// File: rtl/plot_arbiter.sv
// plot_arbiter: clears the frame buffer, then serialises pixel writes from three channels to vga_adapter.
// Latency: one cycle from a sampled request to its registered ack and pixel; the sweep emits one pixel per cycle.
// Backpressure: req/ack handshake. Requests are held, not acked, while a clear sweep runs.
// Ports: clk, resetn (async, active-low); clear_req; er_*/hd_*/fd_* request channels (priority er > hd > fd);
//        x/y/colour/plot: registered pixel stream; busy: clear in progress; oob: granted write was dropped.
// Build option: define BORDER_EN to sweep a BORDER_COLOUR frame and to reject writes that target border pixels.
module plot_arbiter #(
    parameter int unsigned WIDTH         = 160,
    parameter int unsigned HEIGHT        = 120,
    parameter logic [2:0]  CLEAR_COLOUR  = 3'b000,
    parameter logic [2:0]  BORDER_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear_req,
    input  logic       er_req,
    output logic       er_ack,
    input  logic [7:0] er_x,
    input  logic [6:0] er_y,
    input  logic       hd_req,
    output logic       hd_ack,
    input  logic [7:0] hd_x,
    input  logic [6:0] hd_y,
    input  logic [2:0] hd_c,
    input  logic       fd_req,
    output logic       fd_ack,
    input  logic [7:0] fd_x,
    input  logic [6:0] fd_y,
    input  logic [2:0] fd_c,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       oob
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    state_t     state_q, state_d;
    logic [7:0] sx_q, sx_d;
    logic [6:0] sy_q, sy_d;
    logic       done_q, done_d;     // last sweep pixel already emitted
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       oob_q, oob_d;
    logic [2:0] ack_q, ack_d;       // bit 0 er, bit 1 hd, bit 2 fd

    logic [2:0] elig;
    logic [2:0] win;
    logic [7:0] gx;
    logic [6:0] gy;
    logic [2:0] gc;
    logic       sweep_border;
    logic       grant_border;
    logic       drop;

`ifdef BORDER_EN
    function automatic logic on_border(input logic [7:0] px, input logic [6:0] py);
        return (px == 8'd0) || (px == X_LAST) || (py == 7'd0) || (py == Y_LAST);
    endfunction
`endif

    // Fixed-priority pick. A channel whose ack is high this cycle is still
    // holding the request it was just granted, so it is masked out.
    always_comb begin
        elig = {fd_req, hd_req, er_req} & ~ack_q;
        win  = 3'b000;
        gx   = er_x;
        gy   = er_y;
        gc   = CLEAR_COLOUR;
        if (elig[0]) begin
            win = 3'b001;
        end else if (elig[1]) begin
            win = 3'b010;
            gx  = hd_x;
            gy  = hd_y;
            gc  = hd_c;
        end else if (elig[2]) begin
            win = 3'b100;
            gx  = fd_x;
            gy  = fd_y;
            gc  = fd_c;
        end
`ifdef BORDER_EN
        sweep_border = on_border(sx_q, sy_q);
        grant_border = on_border(gx, gy);
`else
        sweep_border = 1'b0;
        grant_border = 1'b0;
`endif
        drop = (gx > X_LAST) || (gy > Y_LAST) || grant_border;
    end

    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        done_d   = done_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        oob_d    = 1'b0;
        ack_d    = 3'b000;
        case (state_q)
            ST_CLEAR: begin
                if (done_q) begin
                    // One idle cycle after the last sweep pixel, then serve.
                    state_d = ST_SERVE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    sx_d    = '0;
                    sy_d    = '0;
                end else begin
                    plot_d   = 1'b1;
                    x_d      = sx_q;
                    y_d      = sy_q;
                    colour_d = sweep_border ? BORDER_COLOUR : CLEAR_COLOUR;
                    if (sx_q == X_LAST) begin
                        sx_d = '0;
                        if (sy_q == Y_LAST) begin
                            sy_d   = '0;
                            done_d = 1'b1;
                        end else begin
                            sy_d = sy_q + 7'd1;
                        end
                    end else begin
                        sx_d = sx_q + 8'd1;
                    end
                end
            end
            ST_SERVE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                    sx_d    = '0;
                    sy_d    = '0;
                    done_d  = 1'b0;
                end else if (win != 3'b000) begin
                    ack_d = win;
                    if (drop) begin
                        oob_d = 1'b1;
                    end else begin
                        plot_d   = 1'b1;
                        x_d      = gx;
                        y_d      = gy;
                        colour_d = gc;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_CLEAR;
            sx_q     <= '0;
            sy_q     <= '0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b1;
            oob_q    <= 1'b0;
            ack_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            oob_q    <= oob_d;
            ack_q    <= ack_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign oob    = oob_q;
    assign er_ack = ack_q[0];
    assign hd_ack = ack_q[1];
    assign fd_ack = ack_q[2];

endmodule

// File: tb/tb_plot_arbiter.sv
// Testbench for plot_arbiter: directed scenarios plus randomized traffic checked against a request-level model.
module tb_plot_arbiter;

`ifdef BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk;
    logic       resetn;
    logic       clear_req;
    logic       er_req, er_ack;
    logic [7:0] er_x;
    logic [6:0] er_y;
    logic       hd_req, hd_ack;
    logic [7:0] hd_x;
    logic [6:0] hd_y;
    logic [2:0] hd_c;
    logic       fd_req, fd_ack;
    logic [7:0] fd_x;
    logic [6:0] fd_y;
    logic [2:0] fd_c;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, oob;

    int checks = 0;
    int errors = 0;

    // Last pixel actually written, as predicted by the bench.
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] lc;

    // Random-phase requester and model state.
    int rx[3], ry[3], rc[3];
    bit rq[3], pa[3], after_ack[3];

    logic [2:0] c_a, c_b, c_c;

    plot_arbiter dut (
        .clk(clk), .resetn(resetn), .clear_req(clear_req),
        .er_req(er_req), .er_ack(er_ack), .er_x(er_x), .er_y(er_y),
        .hd_req(hd_req), .hd_ack(hd_ack), .hd_x(hd_x), .hd_y(hd_y), .hd_c(hd_c),
        .fd_req(fd_req), .fd_ack(fd_ack), .fd_x(fd_x), .fd_y(fd_y), .fd_c(fd_c),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .oob(oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, er_ack, hd_ack, fd_ack, plot, oob, x, y, colour}
    function automatic logic [23:0] snap();
        return {busy, er_ack, hd_ack, fd_ack, plot, oob, x, y, colour};
    endfunction

    function automatic logic [23:0] mk(input logic [2:0] acks, input logic p, input logic o,
                                       input logic [7:0] ex, input logic [6:0] ey,
                                       input logic [2:0] ec, input logic b);
        return {b, acks, p, o, ex, ey, ec};
    endfunction

    function automatic logic [2:0] exp_col(input int px, input int py);
        if (BORDER && (px == 0 || px == 159 || py == 0 || py == 119)) return 3'b111;
        return 3'b000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] exp);
        logic [23:0] obs;
        obs = snap();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={busy,acks,plot,oob,x,y,c}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        step();
        chk(tag, mk(3'b000, 1'b0, 1'b0, lx, ly, lc, 1'b0));
    endtask

    // Expects the DUT to be one edge away from its first sweep pixel. Checks all
    // 19200 sweep cycles, then the idle SERVE cycle that follows. A clear_req
    // pulse is injected at sweep index pulse_at (negative: none); it must be ignored.
    task automatic sweep_check(input string tag, input int pulse_at,
                               output logic [2:0] ca, output logic [2:0] cb, output logic [2:0] cc);
        int bad;
        int first_i;
        logic [23:0] exp;
        logic [23:0] first_obs, first_exp;
        logic [7:0] px;
        logic [6:0] py;
        bad = 0;
        first_i = -1;
        first_obs = '0;
        first_exp = '0;
        ca = 'x; cb = 'x; cc = 'x;
        for (int i = 0; i < 19200; i++) begin
            if (i == pulse_at) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
            px = 8'(i % 160);
            py = 7'(i / 160);
            exp = mk(3'b000, 1'b1, 1'b0, px, py, exp_col(i % 160, i / 160), 1'b1);
            if (snap() !== exp) begin
                if (bad == 0) begin
                    first_i = i;
                    first_obs = snap();
                    first_exp = exp;
                end
                bad++;
            end
            if (px == 8'd0  && py == 7'd50)  ca = colour;
            if (px == 8'd80 && py == 7'd119) cb = colour;
            if (px == 8'd80 && py == 7'd60)  cc = colour;
        end
        if (bad != 0)
            $display("note: %s first deviation at sweep index %0d obs=%h exp=%h", tag, first_i, first_obs, first_exp);
        chkv({tag, "_bad_pixels"}, 32'(bad), 32'd0);
        step();
        lx = 8'd159; ly = 7'd119; lc = exp_col(159, 119);
        chk({tag, "_to_serve"}, mk(3'b000, 1'b0, 1'b0, lx, ly, lc, 1'b0));
    endtask

    initial begin
        int w;
        logic [2:0] na;
        logic ep, eo, ok;

        resetn = 1'b1;
        clear_req = 1'b0;
        er_req = 1'b0; er_x = '0; er_y = '0;
        hd_req = 1'b0; hd_x = '0; hd_y = '0; hd_c = '0;
        fd_req = 1'b0; fd_x = '0; fd_y = '0; fd_c = '0;
        #1 resetn = 1'b0;
        #1;
        chk("reset_values", mk(3'b000, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));
        step();
        step();
        chk("reset_held", mk(3'b000, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));

        // T1: full sweep after reset release
        resetn = 1'b1;
        sweep_check("t1_sweep", -1, c_a, c_b, c_c);
        chkv("px_0_50",   32'(c_a), BORDER ? 32'd7 : 32'd0);
        chkv("px_80_119", 32'(c_b), BORDER ? 32'd7 : 32'd0);
        chkv("px_80_60",  32'(c_c), 32'd0);

        // T2: all three channels request together
        er_req = 1'b1; er_x = 8'd5; er_y = 7'd6;
        hd_req = 1'b1; hd_x = 8'd7; hd_y = 7'd8;  hd_c = 3'b010;
        fd_req = 1'b1; fd_x = 8'd9; fd_y = 7'd10; fd_c = 3'b101;
        step(); chk("t2_er", mk(3'b100, 1'b1, 1'b0, 8'd5, 7'd6, 3'b000, 1'b0));
        step(); chk("t2_hd", mk(3'b010, 1'b1, 1'b0, 8'd7, 7'd8, 3'b010, 1'b0));
        er_req = 1'b0;
        step(); chk("t2_fd", mk(3'b001, 1'b1, 1'b0, 8'd9, 7'd10, 3'b101, 1'b0));
        hd_req = 1'b0;
        lx = 8'd9; ly = 7'd10; lc = 3'b101;
        quiet("t2_idle1");
        fd_req = 1'b0;
        quiet("t2_idle2");

        // T3: held request is written on alternate cycles only
        hd_req = 1'b1; hd_x = 8'd10; hd_y = 7'd20; hd_c = 3'b010;
        lx = 8'd10; ly = 7'd20; lc = 3'b010;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k % 2 == 0) chk($sformatf("t3_write%0d", k), mk(3'b010, 1'b1, 1'b0, lx, ly, lc, 1'b0));
            else            chk($sformatf("t3_gap%0d", k),   mk(3'b000, 1'b0, 1'b0, lx, ly, lc, 1'b0));
        end
        hd_req = 1'b0;
        quiet("t3_after");

        // T4: out-of-range x, out-of-range y, then the last in-range pixel
        fd_req = 1'b1; fd_x = 8'd160; fd_y = 7'd5; fd_c = 3'b011;
        step(); chk("t4_x160", mk(3'b001, 1'b0, 1'b1, lx, ly, lc, 1'b0));
        quiet("t4_x160_after");
        fd_x = 8'd5; fd_y = 7'd120;
        step(); chk("t4_y120", mk(3'b001, 1'b0, 1'b1, lx, ly, lc, 1'b0));
        quiet("t4_y120_after");
        fd_x = 8'd159; fd_y = 7'd119; fd_c = 3'b100;
        if (!BORDER) begin lx = 8'd159; ly = 7'd119; lc = 3'b100; end
        step(); chk("t4_corner", mk(3'b001, !BORDER, BORDER, lx, ly, lc, 1'b0));
        quiet("t4_corner_after");
        fd_req = 1'b0;

        // T6: write to a border pixel
        hd_req = 1'b1; hd_x = 8'd0; hd_y = 7'd50; hd_c = 3'b110;
        if (!BORDER) begin lx = 8'd0; ly = 7'd50; lc = 3'b110; end
        step(); chk("t6_border_req", mk(3'b010, !BORDER, BORDER, lx, ly, lc, 1'b0));
        hd_req = 1'b0;
        quiet("t6_after");

        // Anchor write with a known interior pixel
        hd_req = 1'b1; hd_x = 8'd40; hd_y = 7'd40; hd_c = 3'b011;
        lx = 8'd40; ly = 7'd40; lc = 3'b011;
        step(); chk("anchor", mk(3'b010, 1'b1, 1'b0, lx, ly, lc, 1'b0));
        hd_req = 1'b0;
        quiet("anchor_after");

        // Randomized traffic against a request-level model
        for (int c = 0; c < 3; c++) begin
            rq[c] = 1'b0; pa[c] = 1'b0; after_ack[c] = 1'b0;
            rx[c] = 0; ry[c] = 0; rc[c] = 0;
        end
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 3; c++) begin
                if (pa[c]) begin
                    after_ack[c] = 1'b1;          // ack visible now: keep request stable
                end else if (!rq[c] || after_ack[c]) begin
                    after_ack[c] = 1'b0;
                    rq[c] = ($urandom_range(0, 2) != 0);
                    rx[c] = $urandom_range(0, 175);
                    ry[c] = $urandom_range(0, 127);
                    rc[c] = $urandom_range(0, 7);
                end
            end
            er_req = rq[0]; er_x = 8'(rx[0]); er_y = 7'(ry[0]);
            hd_req = rq[1]; hd_x = 8'(rx[1]); hd_y = 7'(ry[1]); hd_c = 3'(rc[1]);
            fd_req = rq[2]; fd_x = 8'(rx[2]); fd_y = 7'(ry[2]); fd_c = 3'(rc[2]);

            w = -1;
            for (int c = 0; c < 3; c++)
                if (w < 0 && rq[c] && !pa[c]) w = c;
            na = 3'b000; ep = 1'b0; eo = 1'b0;
            if (w >= 0) begin
                na[2 - w] = 1'b1;
                ok = (rx[w] < 160) && (ry[w] < 120) &&
                     !(BORDER && (rx[w] == 0 || rx[w] == 159 || ry[w] == 0 || ry[w] == 119));
                ep = ok;
                eo = !ok;
                if (ok) begin
                    lx = 8'(rx[w]);
                    ly = 7'(ry[w]);
                    lc = (w == 0) ? 3'b000 : 3'(rc[w]);
                end
            end
            step();
            chk($sformatf("rnd%0d", k), mk(na, ep, eo, lx, ly, lc, 1'b0));
            pa[0] = na[2]; pa[1] = na[1]; pa[2] = na[0];
        end
        er_req = 1'b0; hd_req = 1'b0; fd_req = 1'b0;
        step();
        step();

        // T5: clear_req raised in the cycle a write is acked, with hd_req still pending
        hd_req = 1'b1; hd_x = 8'd33; hd_y = 7'd44; hd_c = 3'b110;
        lx = 8'd33; ly = 7'd44; lc = 3'b110;
        step(); chk("t5_pre_write", mk(3'b010, 1'b1, 1'b0, lx, ly, lc, 1'b0));
        clear_req = 1'b1;
        step(); chk("t5_clear_entry", mk(3'b000, 1'b0, 1'b0, lx, ly, lc, 1'b1));
        clear_req = 1'b0;
        sweep_check("t5_sweep", 100, c_a, c_b, c_c);
        lx = 8'd33; ly = 7'd44; lc = 3'b110;
        step(); chk("t5_pending_ack", mk(3'b010, 1'b1, 1'b0, lx, ly, lc, 1'b0));
        hd_req = 1'b0;
        step();

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        step(); chk("t5_clear2", mk(3'b000, 1'b0, 1'b0, lx, ly, lc, 1'b1));
        clear_req = 1'b0;
        repeat (500) step();
        chkv("t5_mid_plot", 32'(plot), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_async", mk(3'b000, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));
        step();
        chk("t5_rst_held", mk(3'b000, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1));
        resetn = 1'b1;
        sweep_check("t5_after_rst", -1, c_a, c_b, c_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
